// File: rtl/soc_mem_loader_if.sv
// Byte-stream input and memory write-port bundle for the program loader.
// slave = the loader itself, master = whatever feeds the stream and watches the RAM port.
interface soc_mem_loader_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LB  = $clog2(NB);
    localparam int MAW = ADDR_WIDTH - LB;

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  abort;
    logic [NUM_CH-1:0]     mem_we;
    logic [MAW-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
    );
endinterface

// File: rtl/soc_mem_loader.sv
// Framed byte-stream loader writing little-endian words into NUM_CH byte-lane RAMs.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit payload checksum byte.
//
// state  | meaning
// S_IDLE | waiting for a command byte
// S_ADDR | collecting 4 LE start-address bytes
// S_LEN  | collecting 4 LE payload-length bytes
// S_DATA | payload bytes, words handed to the write port
// S_CSUM | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
module soc_mem_loader #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    soc_mem_loader_if.slave  bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LB  = $clog2(NB);
    localparam int LW  = (LB > 0) ? LB : 1;
    localparam int MAW = ADDR_WIDTH - LB;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [31:0]           hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           len_q, len_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [NB-1:0]         acc_be_q, acc_be_d;
    logic [7:0]            csum_q, csum_d;
    logic [NUM_CH-1:0]     we_q, we_d;
    logic [MAW-1:0]        waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  cmd_ok;
    logic [LW-1:0]         lane;
    logic [31:0]           hdr_next;
    logic [DATA_WIDTH-1:0] acc_merged;
    logic [NB-1:0]         be_merged;

    assign bus.in_ready  = !bus.abort;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    assign cmd_ok   = (bus.in_data[7:4] == 4'hC) && (int'(bus.in_data[3:0]) < NUM_CH);
    assign lane     = (LB > 0) ? addr_q[LW-1:0] : '0;
    assign hdr_next = {bus.in_data, hdr_q[31:8]};

    always_comb begin
        acc_merged                = acc_q;
        be_merged                 = acc_be_q;
        acc_merged[8*lane +: 8]   = bus.in_data;
        be_merged[lane]           = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        hdr_d    = hdr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        acc_d    = acc_q;
        acc_be_d = acc_be_q;
        csum_d   = csum_q;
        we_d     = '0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (bus.abort) begin
            // Abort drops the partial word silently; no write, no status pulse.
            state_d  = S_IDLE;
            acc_d    = '0;
            acc_be_d = '0;
        end else if (bus.in_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_ok) begin
                        state_d  = S_ADDR;
                        ch_d     = CHW'(bus.in_data[3:0]);
                        cnt_d    = 2'd0;
                        acc_d    = '0;
                        acc_be_d = '0;
                        csum_d   = 8'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_ADDR: begin
                    hdr_d = hdr_next;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        addr_d  = hdr_next[ADDR_WIDTH-1:0];
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    hdr_d = hdr_next;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        len_d = hdr_next;
                        if (hdr_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    addr_d   = addr_q + 1'b1;
                    len_d    = len_q - 32'd1;
                    csum_d   = csum_q + bus.in_data;
                    acc_d    = acc_merged;
                    acc_be_d = be_merged;
                    // Hand the word off and clear the accumulator in the same cycle, so no stall.
                    if (lane == LW'(NB - 1) || len_q == 32'd1) begin
                        we_d[ch_q] = 1'b1;
                        waddr_d    = MAW'(addr_q >> LB);
                        wdata_d    = acc_merged;
                        be_d       = be_merged;
                        acc_d      = '0;
                        acc_be_d   = '0;
                    end
                    if (len_q == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (bus.in_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            hdr_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            acc_be_q <= '0;
            csum_q   <= '0;
            we_q     <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            hdr_q    <= hdr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            acc_be_q <= acc_be_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule
